// File: rtl/radix4_seq_multiplier.sv
// radix4_seq_multiplier
// Sequential unsigned multiplier. Each RUN cycle it consumes two bits of the
// multiplier and adds the matching 2-bit lookup partial product of the
// multiplicand, shifted by 2*cnt, into a 2*SIZE-bit accumulator.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   start  operation request, sampled only while ready=1
//   A, B   multiplicand / multiplier, latched on an accepted start
//   ready  high only in IDLE
//   busy   high only in RUN
//   done   one-cycle pulse, M freshly updated
//   M      product, held until the next completion
//
// Optional build macro RADIX4_SEQ_MULT_EARLY_EXIT_EN: finish RUN as soon as
// the remaining multiplier bits are all zero. Results are unchanged, only
// the latency shrinks.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// RUN   | one radix-4 digit of B accumulated per cycle
// DONE  | done pulse; M holds the new product
module radix4_seq_multiplier #(
  parameter int SIZE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE-1:0]   A,
  input  logic [SIZE-1:0]   B,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] M
);

  localparam int STEPS = SIZE / 2;
  // Keep the counter at least one bit wide when SIZE=2 (a single digit).
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [SIZE-1:0]   a_r;
  logic [SIZE-1:0]   b_sh;
  logic [2*SIZE-1:0] acc;
  logic [CW-1:0]     cnt;

  logic [SIZE+1:0]   pp;
  logic [2*SIZE-1:0] pp_shifted;
  logic [2*SIZE-1:0] acc_next;
  logic [SIZE-1:0]   b_next;
  logic              finish;

  always_comb begin
    pp = '0;
    case (b_sh[1:0])
      2'b00: pp = '0;
      2'b01: pp = {2'b00, a_r};
      2'b10: pp = {1'b0, a_r, 1'b0};
      2'b11: pp = {1'b0, a_r, 1'b0} + {2'b00, a_r};
      default: pp = '0;
    endcase
  end

  // Shift amount is 2*cnt; appending a zero bit doubles cnt without a multiply.
  assign pp_shifted = (2*SIZE)'(pp) << {cnt, 1'b0};
  assign acc_next   = acc + pp_shifted;
  assign b_next     = b_sh >> 2;

`ifdef RADIX4_SEQ_MULT_EARLY_EXIT_EN
  // b_next is always zero after the last digit, so this also covers the
  // full-length case.
  assign finish = (b_next == '0);
`else
  assign finish = (cnt == CW'(STEPS - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) next_state = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (finish) next_state = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r  <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
      M    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r  <= A;
            b_sh <= B;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        S_RUN: begin
          acc  <= acc_next;
          b_sh <= b_next;
          cnt  <= cnt + CW'(1);
          if (finish) M <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_seq_multiplier.sv
// Self-checking bench for radix4_seq_multiplier (SIZE=4). Products are
// checked against plain integer multiplication; RUN length against the
// number of radix-4 digits the operation is expected to take.
module tb_radix4_seq_multiplier;

  localparam int SIZE = 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic [SIZE-1:0]   A;
  logic [SIZE-1:0]   B;
  logic              ready;
  logic              busy;
  logic              done;
  logic [2*SIZE-1:0] M;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  radix4_seq_multiplier #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .M     (M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2*SIZE-1:0] ref_product(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return p[2*SIZE-1:0];
  endfunction

  function automatic int ref_runs(input logic [SIZE-1:0] b);
`ifdef RADIX4_SEQ_MULT_EARLY_EXIT_EN
    int n;
    int unsigned bv;
    n  = 1;
    bv = int'(b);
    while (n < SIZE/2 && (bv >> (2*n)) != 0) n++;
    return n;
`else
    return SIZE/2;
`endif
  endfunction

  // One full operation. With poke set, start is held high with other
  // operands during RUN; it must be ignored and not queued.
  task automatic do_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input bit poke);
    int runs;
    logic [2*SIZE-1:0] exp;
    exp = ref_product(a, b);
    @(negedge clk);
    check("ready_before", ready, 1);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = SIZE'($urandom); B = SIZE'($urandom);
    check("ready_drop", ready, 0);
    runs = 0;
    while (busy && runs < 4*SIZE) begin
      if (poke) begin
        start = 1'b1; A = 3; B = 3;
      end
      check("no_early_done", done, 0);
      @(negedge clk);
      runs++;
    end
    start = 1'b0;
    check("run_len", runs, ref_runs(b));
    check("done_pulse", done, 1);
    check("product", M, exp);
    @(negedge clk);
    check("done_clear", done, 0);
    check("ready_after", ready, 1);
    check("product_hold", M, exp);
    if (poke) begin
      @(negedge clk);
      check("not_queued", busy, 0);
    end
  endtask

  initial begin
    int n;
    int t1;
    reset = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_M", M, 0);

    do_op(13, 11, 0);
    do_op(15, 15, 0);
    do_op(0, 9, 0);
    do_op(9, 0, 0);
    do_op(7, 5, 1);

    // Reset in the second RUN cycle discards the operation.
    @(negedge clk);
    A = 9; B = 14; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ready", ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_M", M, 0);
    do_op(9, 14, 0);

    // start held high across two operations.
    @(negedge clk);
    A = 2; B = 3; start = 1'b1;
    n = 0;
    @(negedge clk);
    while (!done && n < 50) begin @(negedge clk); n++; end
    check("held1_done", done, 1);
    check("held1_M", M, 6);
    t1 = cyc;
    A = 5; B = 6;
    @(negedge clk);
    n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    start = 1'b0;
    check("held2_done", done, 1);
    check("held2_M", M, 30);
    check("held_spacing", cyc - t1, ref_runs(6) + 2);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      do_op(SIZE'($urandom), SIZE'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/radix4_seq_multiplier.md
Name: radix4_seq_multiplier

Overview:
- Sequential unsigned multiplier. Consumes the multiplier operand two bits per clock.
- Each cycle it forms the same 2-bit lookup partial product used by the combinational 2-bit LUT multiplier stage (00→0, 01→A, 10→A<<1, 11→(A<<1)+A).
- Accumulates the shifted partial products into a 2*SIZE-bit result.
- Sits directly downstream of the operand source and feeds the result/display stage; uses a start/ready/done handshake.

Parameters:
- SIZE, 4, operand width in bits for A and B; must be even and ≥2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- A  input  SIZE  multiplicand; latched on accepted start
- B  input  SIZE  multiplier; latched on accepted start
- ready  output  1  high only in IDLE
- busy  output  1  high only in RUN
- done  output  1  one-cycle pulse; M valid and newly updated
- M  output  2*SIZE  product; holds last result until the next completion

Behaviour:
- Reset (sampled at a clk edge with reset=1):
  - state=IDLE; M=0; done=0; busy=0; ready=1.
  - Internal accumulator, shift register and counter are cleared.
  - Reset dominates every other input, including mid-RUN; any in-flight result is discarded.
- States:
  - IDLE: ready=1. On start=1 at an edge: latch A→a_r, B→b_sh; acc=0; cnt=0; go to RUN.
  - RUN: busy=1. Each edge:
    - pp = lut(a_r, b_sh[1:0]); pp is SIZE+2 bits wide, zero-extended.
    - acc = acc + (pp << 2*cnt), truncated to 2*SIZE bits (no overflow possible).
    - b_sh = b_sh >> 2; cnt = cnt+1.
    - If cnt was SIZE/2-1: M = new acc value; go to DONE.
  - DONE: done=1 for exactly this cycle; ready=0; next edge goes to IDLE unconditionally.
- Start handling:
  - start while in RUN or DONE is ignored; it is not queued.
  - start held high continuously re-triggers on the first IDLE cycle.
- Latency (base): start accepted at edge e0; RUN spans edges e1..e(SIZE/2); M updates and done rises after edge e(SIZE/2); back in IDLE after e(SIZE/2+1).
  - SIZE=4: done is high 2 cycles after the accept edge.
  - Throughput is one product per SIZE/2+2 cycles.
- A or B changing after acceptance has no effect on the running operation.
- B=0 or A=0: full RUN length still executes (base build); M=0.
- Maximum operands (all ones): M = (2^SIZE−1)^2, exact.
- Outputs ready, busy and done are decoded from registered state only; there is no combinational path from start.

Optional Feature:
- Macro: RADIX4_SEQ_MULT_EARLY_EXIT_EN.
- Defined: in RUN, if the post-shift b_sh is zero after the current update, M = acc and go to DONE immediately, regardless of cnt.
  - Minimum RUN length is 1 cycle, e.g. B=0 or B=1.
  - Results are identical to the base build; only latency shrinks.
- Undefined: fixed SIZE/2 RUN cycles, exactly as in Behaviour.

Test Plan:
- Reset, then SIZE=4, A=13, B=11, start one cycle → ready drops; busy for 2 cycles; done pulse one cycle; M=143; ready high the cycle after done.
- A=15, B=15 → M=225. Then A=0, B=9 → M=0, with done still after 2 RUN cycles in the base build.
- Accept A=7, B=5 then, while busy, assert start with A=3, B=3 and change A/B → ignored; M=35; only one done pulse.
- Assert reset during the second RUN cycle of A=9, B=14 → next cycle state IDLE, M=0, done=0, ready=1. A fresh start A=9, B=14 → M=126.
- Hold start high across two operations (A=2, B=3, then A=5, B=6) → M=6, then M=30 after the next accept from IDLE; done pulses spaced SIZE/2+2 cycles apart.
- With RADIX4_SEQ_MULT_EARLY_EXIT_EN, SIZE=8: A=200, B=3 → 1 RUN cycle, M=600. A=200, B=255 → 4 RUN cycles, M=51000.
